// File: rtl/qq_pkg.sv
// Shared types and constants for the quick-queue command sequencer.
// Opcodes, response status codes, FSM state encodings and the occupancy step helper.
package qq_pkg;

  typedef enum logic {
    OP_ENQ = 1'b0,
    OP_DEQ = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_FULL    = 2'd1,
    ST_EMPTY   = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef logic [1:0] state_e;
  localparam state_e S_IDLE      = 2'd0;
  localparam state_e S_ISSUE     = 2'd1;
  localparam state_e S_WAIT_DONE = 2'd2;
  localparam state_e S_RESP      = 2'd3;

  localparam logic [31:0] EMPTY_VAL = 32'hFFFF_FFFF;
  localparam logic [31:0] ERROR_VAL = 32'h0000_0000;

  // Occupancy moves by one per completed command and sticks at 0 and 255.
  function automatic logic [7:0] occ_step(input logic [7:0] occ, input op_e op);
    if (op == OP_ENQ) return (occ == 8'hFF) ? occ : occ + 8'd1;
    return (occ == 8'h00) ? occ : occ - 8'd1;
  endfunction

endpackage

// File: rtl/qq_cmd_fifo.sv
// Synchronous command FIFO holding {op, key} entries; no same-cycle bypass.
// full is a registered flag and stays asserted while reset is applied.
module qq_cmd_fifo
  import qq_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  op_e          push_op,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output op_e          head_op,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          ready;
  logic          do_push;
  logic          do_pop;

  assign full      = !ready;
  assign empty     = (count == '0);
  assign do_push   = push && ready;
  assign do_pop    = pop && !empty;
  assign head_op   = op_e'(mem[rd_ptr][W]);
  assign head_data = mem[rd_ptr][W-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next < DEPTH_C);
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count already empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_op, push_data};
  end

endmodule

// File: rtl/qq_cmd_sequencer.sv
// Host front end for the quick queue: buffers ENQ/DEQ commands, issues them one at a
// time with a strobe/done handshake and returns exactly one response per command.
module qq_cmd_sequencer
  import qq_pkg::*;
#(
  parameter int W           = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic         cmd_op_i,
  input  logic [W-1:0] cmd_data_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [W-1:0] rsp_data_o,
  output logic [1:0]   rsp_status_o,
  input  logic [7:0]   array_size_i,
  output logic [W-1:0] q_data_o,
  output logic         q_write_o,
  output logic         q_read_o,
  input  logic         q_done_i,
  input  logic [W-1:0] q_data_i,
  output logic [7:0]   occupancy_o
);

  localparam logic [W-1:0] EMPTY_D = {W{1'b1}};
  localparam logic [W-1:0] ERROR_D = '0;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state;
  op_e           cur_op;
  status_e       rsp_status;
  logic [TW-1:0] tmo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  op_e           head_op;
  logic [W-1:0]  head_data;

  assign cmd_ready_o  = !fifo_full;
  assign push         = cmd_valid_i && !fifo_full;
  // A response handshake frees the engine, so the next command can pop on the same edge.
  assign pop          = !fifo_empty &&
                        ((state == S_IDLE) || ((state == S_RESP) && rsp_ready_i));
  assign rsp_valid_o  = (state == S_RESP);
  assign rsp_status_o = rsp_status;
  assign q_write_o    = (state == S_ISSUE) && (cur_op == OP_ENQ);
  assign q_read_o     = (state == S_ISSUE) && (cur_op == OP_DEQ);

  qq_cmd_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_op   (op_e'(cmd_op_i)),
    .push_data (cmd_data_i),
    .pop       (pop),
    .head_op   (head_op),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_op      <= OP_ENQ;
      rsp_status  <= ST_OK;
      rsp_data_o  <= '0;
      q_data_o    <= '0;
      tmo_cnt     <= '0;
      occupancy_o <= 8'd0;
    end else if (pop) begin
      cur_op   <= head_op;
      q_data_o <= head_data;
      // Capacity checks use occupancy and array_size as seen at the pop edge only.
      if ((head_op == OP_ENQ) && (occupancy_o >= array_size_i)) begin
        state      <= S_RESP;
        rsp_status <= ST_FULL;
        rsp_data_o <= ERROR_D;
      end else if ((head_op == OP_DEQ) && (occupancy_o == 8'd0)) begin
        state      <= S_RESP;
        rsp_status <= ST_EMPTY;
        rsp_data_o <= EMPTY_D;
      end else begin
        state <= S_ISSUE;
      end
    end else begin
      case (state)
        S_ISSUE: begin
          state   <= S_WAIT_DONE;
          tmo_cnt <= '0;
        end
        S_WAIT_DONE: begin
          if (q_done_i) begin
            state       <= S_RESP;
            rsp_status  <= ST_OK;
            rsp_data_o  <= (cur_op == OP_DEQ) ? q_data_i : ERROR_D;
            occupancy_o <= occ_step(occupancy_o, cur_op);
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= S_RESP;
            rsp_status <= ST_TIMEOUT;
            rsp_data_o <= ERROR_D;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
